clk_ratio_monitor: RTL and testbench

Single-clock monitor that checks a divided clock against the master clock. It samples one divided clock (`clk_in`, e.g. a clk/2 … clk/32 tap) on `clk`, measures each period in `clk` cycles and compares it with the ratio selected by `sel`. It reports `locked` after a run of consecutive correct periods and raises a sticky `error` on any deviation once locked. It sits next to the ripple divider chain as its built-in health check.

---
 rtl/clk_ratio_monitor.sv | 177 +++++++++++++++++
 tb/tb_clk_ratio_monitor.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_ratio_monitor.sv
// clk_ratio_monitor: checks a divided clock tap against the ratio chosen by sel; CLK_MON_TIMEOUT_EN adds stopped-clock timeout.
// Latency: rise seen SYNC_STAGES+1 cycles after a clk_in edge; period/period_valid/locked register on the rise cycle.
// Backpressure: none, passive observer; period_valid is a single-cycle pulse with no handshake.
module clk_ratio_monitor #(
    parameter int CNT_W       = 8,
    parameter int LOCK_N      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_in,
    input  logic             enable,
    input  logic [2:0]       sel,
    input  logic             clear,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             error
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACQUIRE,
        ST_MEASURE,
        ST_LOCKED,
        ST_ERROR
    } state_t;

    localparam logic [3:0] LOCK_V = 4'(LOCK_N);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [2:0]             sel_q, sel_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             mcnt_q, mcnt_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic                   pv_q, pv_d;
    logic                   locked_q, locked_d;
    logic                   error_q, error_d;

    logic                   synced;
    logic                   rise;
    logic                   sel_chg;
    logic                   in_run;
    logic                   match;
    logic                   tmo_hit;
    logic [2:0]             eff_sel;
    logic [CNT_W-1:0]       exp_ratio;

    assign synced    = sync_q[SYNC_STAGES-1];
    assign rise      = synced & ~prev_q;
    assign sel_chg   = (sel != sel_q);
    // Selects 5..7 have no tap of their own; they alias the slowest ratio.
    assign eff_sel   = (sel > 3'd4) ? 3'd4 : sel;
    assign exp_ratio = CNT_W'(2) << eff_sel;
    assign match     = (cnt_q == exp_ratio);
    assign in_run    = (state_q == ST_MEASURE) || (state_q == ST_LOCKED) || (state_q == ST_ERROR);

`ifdef CLK_MON_TIMEOUT_EN
    // Fires once: cnt passes the threshold exactly once before saturating.
    assign tmo_hit   = (cnt_q == (exp_ratio << 1)) && !rise;
`else
    assign tmo_hit   = 1'b0;
`endif

    // Front end: synchronizer shift, edge history, sel history, period counter
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], clk_in};
        prev_d = synced;
        sel_d  = sel;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (rise) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == {CNT_W{1'b1}}) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Next-state and output decisions; enable, then clear/sel restart, then per-state evaluation
    always_comb begin
        state_d  = state_q;
        mcnt_d   = mcnt_q;
        period_d = period_q;
        pv_d     = 1'b0;
        locked_d = locked_q;
        // error is sticky and lags ERROR entry by one cycle; only clear drops it
        error_d  = clear ? 1'b0 : (error_q | (state_q == ST_ERROR));

        if (!enable) begin
            state_d  = ST_IDLE;
            mcnt_d   = '0;
            locked_d = 1'b0;
        end else if (clear || sel_chg) begin
            state_d  = ST_ACQUIRE;
            mcnt_d   = '0;
            locked_d = 1'b0;
        end else begin
            if (rise && in_run) begin
                period_d = cnt_q;
                pv_d     = 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    // first edge only arms the counter; the partial period before it is discarded
                    if (rise) begin
                        state_d = ST_MEASURE;
                        mcnt_d  = '0;
                    end
                end
                ST_MEASURE: begin
                    if (rise) begin
                        if (match) begin
                            mcnt_d = mcnt_q + 4'd1;
                            if (mcnt_q + 4'd1 == LOCK_V) begin
                                state_d  = ST_LOCKED;
                                locked_d = 1'b1;
                            end
                        end else begin
                            mcnt_d = '0;
                        end
                    end else if (tmo_hit) begin
                        mcnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if ((rise && !match) || tmo_hit) begin
                        state_d  = ST_ERROR;
                        locked_d = 1'b0;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            sync_q   <= '0;
            prev_q   <= 1'b0;
            sel_q    <= '0;
            cnt_q    <= '0;
            mcnt_q   <= '0;
            period_q <= '0;
            pv_q     <= 1'b0;
            locked_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            prev_q   <= prev_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            mcnt_q   <= mcnt_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            locked_q <= locked_d;
            error_q  <= error_d;
        end
    end

    assign period       = period_q;
    assign period_valid = pv_q;
    assign locked       = locked_q;
    assign error        = error_q;

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// tb_clk_ratio_monitor: directed scenarios against a timestamp-based model of the ratio monitor.
// Latency: model outputs line up with DUT register outputs, both compared at every falling edge.
// Backpressure: none; the bench drives clk_in as a synchronous divided clock it controls.
module tb_clk_ratio_monitor;

    localparam int CNT_W   = 8;
    localparam int LOCK_N  = 4;
    localparam int SS      = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             clk_in = 1'b0;
    logic             enable;
    logic [2:0]       sel;
    logic             clear;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             error;

    int n_chk  = 0;
    int n_fail = 0;

    clk_ratio_monitor #(.CNT_W(CNT_W), .LOCK_N(LOCK_N), .SYNC_STAGES(SS)) dut (
        .clk          (clk),
        .reset        (reset),
        .clk_in       (clk_in),
        .enable       (enable),
        .sel          (sel),
        .clear        (clear),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .error        (error)
    );

    always #5 clk = ~clk;

    // Divided clock source: high for the first half of each ratio window, restarts phase on change
    int ratio = 4;
    int cur_ratio = 0;
    int ph = 0;
    bit stopped = 1'b1;
    always @(negedge clk) begin
        if (stopped || ratio < 2) begin
            clk_in = 1'b0;
            ph = 0;
        end else begin
            if (ratio != cur_ratio) begin
                cur_ratio = ratio;
                ph = 0;
            end
            clk_in = (ph < ratio / 2);
            ph = (ph + 1 >= ratio) ? 0 : ph + 1;
        end
    end

    // Model: rises come from a delayed copy of clk_in, periods are timestamp differences
    typedef enum {M_IDLE, M_ACQ, M_MEAS, M_LOCK, M_ERR} mphase_t;
    mphase_t mode = M_IDLE;
    bit hist [0:SS];
    int k = 0;
    int last_rise = 0;
    int last_sel = 0;
    int run = 0;
    int m_period = 0;
    bit m_pv = 1'b0;
    bit m_locked = 1'b0;
    bit m_err = 1'b0;
    bit r, tmo, chg, good, err_next;
    int span, want, eff;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode = M_IDLE;
            for (int i = 0; i <= SS; i++) hist[i] = 1'b0;
            k = 0; last_rise = 0; last_sel = 0; run = 0;
            m_period = 0; m_pv = 1'b0; m_locked = 1'b0; m_err = 1'b0;
        end else begin
            k++;
            r    = hist[SS-1] && !hist[SS];
            span = k - last_rise;
            if (span > CNT_MAX) span = CNT_MAX;
            eff  = (int'(sel) > 4) ? 4 : int'(sel);
            want = 2 << eff;
            chg  = (int'(sel) != last_sel);
`ifdef CLK_MON_TIMEOUT_EN
            tmo  = !r && (span == 2 * want);
`else
            tmo  = 1'b0;
`endif
            err_next = !clear && (m_err || mode == M_ERR);
            m_pv = 1'b0;
            good = 1'b0;
            if (!enable) begin
                mode = M_IDLE; run = 0;
            end else if (clear || chg) begin
                mode = M_ACQ; run = 0;
            end else begin
                if (r && (mode == M_MEAS || mode == M_LOCK || mode == M_ERR)) begin
                    m_pv = 1'b1;
                    m_period = span;
                    good = (span == want);
                end
                case (mode)
                    M_IDLE: mode = M_ACQ;
                    M_ACQ:  if (r) begin mode = M_MEAS; run = 0; end
                    M_MEAS: begin
                        if (m_pv) begin
                            run = good ? run + 1 : 0;
                            if (run == LOCK_N) mode = M_LOCK;
                        end else if (tmo) begin
                            run = 0;
                        end
                    end
                    M_LOCK: if ((m_pv && !good) || tmo) mode = M_ERR;
                    default: ;
                endcase
            end
            m_err = err_next;
            m_locked = (mode == M_LOCK);
            if (r) last_rise = k;
            last_sel = int'(sel);
            for (int i = SS; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = clk_in;
        end
    end

    task automatic check(input string name, input int act, input int expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        check("cyc_period", int'(period), m_period);
        check("cyc_period_valid", int'(period_valid), int'(m_pv));
        check("cyc_locked", int'(locked), int'(m_locked));
        check("cyc_error", int'(error), int'(m_err));
    end

    task automatic wait_locked(input int budget, output int pvs, output bit ok);
        pvs = 0;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (period_valid) pvs++;
            if (locked) ok = 1'b1;
        end
    endtask

    task automatic wait_clk_in_low(output bit ok);
        int lows;
        lows = 0;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            #1;
            lows = (clk_in == 1'b0) ? lows + 1 : 0;
            if (lows >= 3) ok = 1'b1;
        end
    endtask

    initial begin
        int pvs;
        bit ok;
        reset = 1'b0; enable = 1'b1; sel = 3'd1; clear = 1'b0; ratio = 4; stopped = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_period", int'(period), 0);
        check("rst_period_valid", int'(period_valid), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_error", int'(error), 0);
        reset = 1'b1;
        @(negedge clk);
        stopped = 1'b0;

        // ratio 4 at sel 1: lock on the 4th valid period
        wait_locked(100, pvs, ok);
        check("t1_lock", int'(ok), 1);
        check("t1_pv_count", pvs, 4);
        check("t1_period", int'(period), 4);
        check("t1_error", int'(error), 0);

        // clear while locked, then ratio 8 at sel 1: never locks, no error
        @(negedge clk);
        clear = 1'b1; ratio = 8;
        @(negedge clk);
        clear = 1'b0;
        check("t2_clear_unlock", int'(locked), 0);
        repeat (200) @(negedge clk);
        check("t2_locked", int'(locked), 0);
        check("t2_error", int'(error), 0);
        check("t2_period", int'(period), 8);

        // lock at ratio 16, then stop clk_in
        sel = 3'd3; ratio = 16;
        wait_locked(300, pvs, ok);
        check("t3_lock", int'(ok), 1);
        stopped = 1'b1;
`ifdef CLK_MON_TIMEOUT_EN
        repeat (40) @(negedge clk);
        check("t3_tmo_error", int'(error), 1);
        check("t3_tmo_locked", int'(locked), 0);
`else
        repeat (100) @(negedge clk);
        check("t3_stopped_locked", int'(locked), 1);
        check("t3_stopped_error", int'(error), 0);
`endif
        stopped = 1'b0; ratio = 8;
        repeat (60) @(negedge clk);
        check("t3_error", int'(error), 1);
        check("t3_unlocked", int'(locked), 0);

        // enable low drops to idle but keeps error
        enable = 1'b0;
        repeat (5) @(negedge clk);
        check("en_locked", int'(locked), 0);
        check("en_error_kept", int'(error), 1);
        enable = 1'b1;

        // ratio 2 clock, clear with sel 0
        ratio = 2;
        repeat (20) @(negedge clk);
        check("t4_sticky", int'(error), 1);
        sel = 3'd0; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("t4_cleared", int'(error), 0);
        check("t4_unlocked", int'(locked), 0);
        wait_locked(100, pvs, ok);
        check("t4_lock", int'(ok), 1);
        check("t4_pv_count", pvs, 4);
        check("t4_period", int'(period), 2);

        // lock at sel 2, then switch to sel 4 with a ratio-32 input
        sel = 3'd2; ratio = 8;
        wait_locked(200, pvs, ok);
        check("t5_lock8", int'(ok), 1);
        wait_clk_in_low(ok);
        check("t5_align", int'(ok), 1);
        sel = 3'd4; ratio = 32;
        @(negedge clk);
        check("t5_reacquire", int'(locked), 0);
        wait_locked(400, pvs, ok);
        check("t5_lock32", int'(ok), 1);
        check("t5_pv_count", pvs, 4);
        check("t5_error", int'(error), 0);
        check("t5_period", int'(period), 32);

        // illegal sel 5 behaves as ratio 32
        sel = 3'd5;
        @(negedge clk);
        check("t5b_reacquire", int'(locked), 0);
        wait_locked(400, pvs, ok);
        check("t5b_lock", int'(ok), 1);
        check("t5b_pv_count", pvs, 4);
        check("t5b_period", int'(period), 32);

        // asynchronous reset while locked
        @(posedge clk);
        #2;
        reset = 1'b0; stopped = 1'b1;
        #1;
        check("t6_period", int'(period), 0);
        check("t6_period_valid", int'(period_valid), 0);
        check("t6_locked", int'(locked), 0);
        check("t6_error", int'(error), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        stopped = 1'b0;
        wait_locked(400, pvs, ok);
        check("t6_relock", int'(ok), 1);
        check("t6_pv_count", pvs, 4);
        check("t6_error_after", int'(error), 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
